// File: rtl/banked_byte_ram.sv
// banked_byte_ram: dual-port banked byte RAM with round-robin bank arbitration; `define RAM_BOUNDS_CHECK_EN to flag out-of-range words
module banked_byte_ram #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BANKS      = 2,
  parameter int WORDS_PER_BANK = 256,
  parameter int READ_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req,
  input  logic                    a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  output logic                    a_gnt,
  output logic                    a_rvalid,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  output logic                    a_err,
  input  logic                    b_req,
  input  logic                    b_we,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  output logic                    b_gnt,
  output logic                    b_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int BO = $clog2(NB);
  localparam int BW = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  localparam int RW = WORDS_PER_BANK > 1 ? $clog2(WORDS_PER_BANK) : 1;
  localparam int WB = $clog2(NUM_BANKS * WORDS_PER_BANK);
  localparam int L  = READ_LATENCY;
  logic [1:0] req, we, gnt, oor, rd, wr;
  logic [ADDR_WIDTH-1:0] word [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [NB-1:0] be [2];
  logic [BW-1:0] bank [2];
  logic [RW-1:0] row [2];
  logic conflict, prio_b;
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][WORDS_PER_BANK];
  logic vld [2][L];
  logic err [2][L];
  logic [DATA_WIDTH-1:0] dat [2][L];
  assign req = {b_req, a_req};
  assign we = {b_we, a_we};
  assign word[0] = a_addr >> BO;
  assign word[1] = b_addr >> BO;
  assign wdata[0] = a_wdata;
  assign wdata[1] = b_wdata;
  assign be[0] = a_be;
  assign be[1] = b_be;
  for (genvar i = 0; i < 2; i++) begin : g_port
    assign bank[i] = BW'(word[i] % NUM_BANKS);
    assign row[i] = RW'((word[i] / NUM_BANKS) % WORDS_PER_BANK);
`ifdef RAM_BOUNDS_CHECK_EN
    assign oor[i] = |(word[i] >> WB);
`else
    assign oor[i] = 1'b0;
`endif
    assign rd[i] = gnt[i] && !we[i];
    assign wr[i] = gnt[i] && we[i] && !oor[i];
  end
  assign conflict = &req && bank[0] == bank[1];
  assign gnt[0] = !rst && req[0] && !(conflict && prio_b);
  assign gnt[1] = !rst && req[1] && !(conflict && !prio_b);
  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];
  always_ff @(posedge clk) begin
    if (rst)
      prio_b <= 1'b0;
    else if (conflict)
      prio_b <= !prio_b;
  end
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++)
      if (wr[p])
        for (int j = 0; j < NB; j++)
          if (be[p][j])
            mem[bank[p]][row[p]][j*8 +: 8] <= wdata[p][j*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < L; k++) begin
          vld[p][k] <= 1'b0;
          err[p][k] <= 1'b0;
          dat[p][k] <= '0;
        end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld[p][0] <= rd[p];
        if (rd[p]) begin
          dat[p][0] <= oor[p] ? '0 : mem[bank[p]][row[p]];
          err[p][0] <= oor[p];
        end
        for (int k = 1; k < L; k++) begin
          vld[p][k] <= vld[p][k-1];
          if (vld[p][k-1]) begin
            dat[p][k] <= dat[p][k-1];
            err[p][k] <= err[p][k-1];
          end
        end
      end
    end
  end
  assign a_rvalid = vld[0][L-1];
  assign a_rdata = dat[0][L-1];
  assign a_err = err[0][L-1] && vld[0][L-1];
  assign b_rvalid = vld[1][L-1];
  assign b_rdata = dat[1][L-1];
  assign b_err = err[1][L-1] && vld[1][L-1];
endmodule

// File: tb/tb_banked_byte_ram.sv
// tb_banked_byte_ram: directed and random stimulus against a byte-array reference model
module tb_banked_byte_ram;
  localparam int AW = 32, DW = 32, NBK = 2, WPB = 256, RL = 2, TW = NBK * WPB;
  logic clk = 1'b0;
  logic rst;
  logic a_req, a_we, a_gnt, a_rvalid, a_err, b_req, b_we, b_gnt, b_rvalid, b_err;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, a_rdata, b_wdata, b_rdata;
  logic [3:0] a_be, b_be;
  logic rq [2], wr [2];
  logic [31:0] ad [2], wd [2];
  logic [3:0] bm [2];
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] mb [TW*4];
  logic ev [2][8], ee [2][8];
  logic [31:0] ed [2][8];
  logic [31:0] last_d [2];
  logic prio_b = 1'b0;
  logic mg [2], g [2];
  always #5 clk = ~clk;
  assign a_req = rq[0];
  assign a_we = wr[0];
  assign a_addr = ad[0];
  assign a_wdata = wd[0];
  assign a_be = bm[0];
  assign b_req = rq[1];
  assign b_we = wr[1];
  assign b_addr = ad[1];
  assign b_wdata = wd[1];
  assign b_be = bm[1];
  banked_byte_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BANKS(NBK),
    .WORDS_PER_BANK(WPB), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int bank_of(input logic [31:0] a);
    return int'((a >> 2) % NBK);
  endfunction
  function automatic bit oor_of(input logic [31:0] a);
`ifdef RAM_BOUNDS_CHECK_EN
    return (a >> 2) >= TW;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int base_of(input logic [31:0] a);
    return int'(((a >> 2) % TW) * 4);
  endfunction
  task automatic set(input int p, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] e);
    rq[p] = r;
    wr[p] = w;
    ad[p] = a;
    wd[p] = d;
    bm[p] = e;
  endtask
  task automatic idle();
    set(0, 0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0, 0);
  endtask
  task automatic cycle();
    int s, t, b, win;
    logic conf;
    logic ov [2], oe [2], og [2];
    logic [31:0] od [2];
    @(negedge clk);
    s = cyc % 8;
    ov = '{a_rvalid, b_rvalid};
    oe = '{a_err, b_err};
    og = '{a_gnt, b_gnt};
    od = '{a_rdata, b_rdata};
    for (int p = 0; p < 2; p++) begin
      if (ev[p][s])
        last_d[p] = ed[p][s];
      chk($sformatf("p%0d_rvalid@%0d", p, cyc), 32'(ov[p]), 32'(ev[p][s]));
      chk($sformatf("p%0d_rdata@%0d", p, cyc), od[p], last_d[p]);
      chk($sformatf("p%0d_err@%0d", p, cyc), 32'(oe[p]), 32'(ev[p][s] && ee[p][s]));
      ev[p][s] = 1'b0;
    end
    conf = rq[0] && rq[1] && bank_of(ad[0]) == bank_of(ad[1]);
    win = prio_b ? 1 : 0;
    for (int p = 0; p < 2; p++) begin
      mg[p] = !rst && rq[p] && (!conf || p == win);
      chk($sformatf("p%0d_gnt@%0d", p, cyc), 32'(og[p]), 32'(mg[p]));
      g[p] = og[p];
    end
    chk("same_bank_gnt", 32'(a_gnt && b_gnt && bank_of(ad[0]) == bank_of(ad[1])), 0);
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        last_d[p] = 0;
        for (int k = 0; k < 8; k++)
          ev[p][k] = 1'b0;
      end
      prio_b = 1'b0;
    end else begin
      if (conf)
        prio_b = (win == 0);
      t = (cyc + RL) % 8;
      for (int p = 0; p < 2; p++)
        if (mg[p] && !wr[p]) begin
          b = base_of(ad[p]);
          ev[p][t] = 1'b1;
          ee[p][t] = oor_of(ad[p]);
          ed[p][t] = oor_of(ad[p]) ? 32'h0 : {mb[b+3], mb[b+2], mb[b+1], mb[b]};
        end
      for (int p = 0; p < 2; p++)
        if (mg[p] && wr[p] && !oor_of(ad[p])) begin
          b = base_of(ad[p]);
          for (int i = 0; i < 4; i++)
            if (bm[p][i])
              mb[b+i] = wd[p][i*8 +: 8];
        end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int p = 0; p < 2; p++) begin
      last_d[p] = 0;
      mg[p] = 0;
      for (int k = 0; k < 8; k++)
        ev[p][k] = 1'b0;
    end
    rst = 1'b1;
    idle();
    set(0, 1, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("rst_a_gnt", 32'(g[0]), 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rvalid", 32'(b_rvalid), 0);
    rst = 1'b0;
    for (int w = 0; w < WPB; w++) begin
      set(0, 1, 1, 32'(2 * w * 4), $urandom, 4'hF);
      set(1, 1, 1, 32'((2 * w + 1) * 4), $urandom, 4'hF);
      cycle();
    end
    idle();
    cycle();
    set(0, 1, 1, 0, 32'hDEADBEEF, 4'hF);
    cycle();
    chk("t1_wgnt", 32'(g[0]), 1);
    set(0, 1, 0, 0, 0, 0);
    cycle();
    chk("t1_rgnt", 32'(g[0]), 1);
    chk("t1_early_rvalid", 32'(a_rvalid), 0);
    idle();
    cycle();
    chk("t1_rvalid", 32'(a_rvalid), 1);
    chk("t1_rdata", a_rdata, 32'hDEADBEEF);
    chk("t1_err", 32'(a_err), 0);
    cycle();
    set(0, 1, 1, 4, 32'hAABBCCDD, 4'hF);
    cycle();
    idle();
    set(1, 1, 1, 4, 32'h11223344, 4'b0101);
    cycle();
    set(1, 1, 0, 4, 0, 0);
    cycle();
    idle();
    cycle();
    chk("t2_rvalid", 32'(b_rvalid), 1);
    chk("t2_rdata", b_rdata, 32'hAA22CC44);
    cycle();
    set(0, 1, 0, 0, 0, 0);
    set(1, 1, 0, 4, 0, 0);
    cycle();
    chk("t3_a_gnt", 32'(g[0]), 1);
    chk("t3_b_gnt", 32'(g[1]), 1);
    idle();
    cycle();
    chk("t3_a_rvalid", 32'(a_rvalid), 1);
    chk("t3_b_rvalid", 32'(b_rvalid), 1);
    chk("t3_a_rdata", a_rdata, 32'hDEADBEEF);
    chk("t3_b_rdata", b_rdata, 32'hAA22CC44);
    cycle();
    set(0, 1, 0, 0, 0, 0);
    set(1, 1, 0, 8, 0, 0);
    cycle();
    chk("t4_c0_a", 32'(g[0]), 1);
    chk("t4_c0_b", 32'(g[1]), 0);
    set(0, 0, 0, 0, 0, 0);
    cycle();
    chk("t4_c1_b", 32'(g[1]), 1);
    idle();
    cycle();
    cycle();
    set(0, 1, 0, 0, 0, 0);
    set(1, 1, 0, 8, 0, 0);
    cycle();
    chk("t4_rep_b", 32'(g[1]), 1);
    chk("t4_rep_a", 32'(g[0]), 0);
    set(1, 0, 0, 0, 0, 0);
    cycle();
    chk("t4_rep_a2", 32'(g[0]), 1);
    idle();
    cycle();
    cycle();
    set(0, 1, 0, 0, 0, 0);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_no_rvalid", 32'(a_rvalid), 0);
    chk("t5_rdata0", a_rdata, 0);
    cycle();
    set(0, 1, 0, 0, 0, 0);
    cycle();
    idle();
    cycle();
    chk("t5_reread_rvalid", 32'(a_rvalid), 1);
    chk("t5_reread", a_rdata, 32'hDEADBEEF);
    cycle();
    set(0, 1, 0, 32'h800, 0, 0);
    cycle();
    idle();
    cycle();
    chk("t6_rvalid", 32'(a_rvalid), 1);
`ifdef RAM_BOUNDS_CHECK_EN
    chk("t6_err", 32'(a_err), 1);
    chk("t6_rdata", a_rdata, 0);
`else
    chk("t6_err", 32'(a_err), 0);
    chk("t6_rdata", a_rdata, 32'hDEADBEEF);
`endif
    cycle();
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++)
        if (!rq[p] || mg[p])
          set(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, TW * 8 - 1)), $urandom, 4'($urandom_range(0, 15)));
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle();
    for (int n = 0; n < 4; n++)
      cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/banked_byte_ram.md
Name: banked_byte_ram

Overview:
- Dual-port, byte-addressed, banked on-chip RAM; next-generation replacement for the single-port word RAM used by the RT core.
- Two independent request ports (A, B), each accepting a full byte address, write data and byte enables.
- Words are interleaved across NUM_BANKS single-port banks; the two ports run in parallel unless they hit the same bank, in which case a round-robin arbiter serialises them.
- Read data returns after a fixed, parametrised pipeline latency.

Parameters:
ADDR_WIDTH, 32, byte address width on each port
DATA_WIDTH, 32, word width; multiple of 8
NUM_BANKS, 2, bank count; power of 2, >=1
WORDS_PER_BANK, 256, words per bank; power of 2
READ_LATENCY, 1, cycles from grant to rvalid; legal range 1..4

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
a_req  input  1  port A request; held until a_gnt
a_we  input  1  port A write (1) / read (0)
a_addr  input  ADDR_WIDTH  port A byte address
a_wdata  input  DATA_WIDTH  port A write data
a_be  input  DATA_WIDTH/8  port A byte enables
a_gnt  output  1  port A request accepted this cycle
a_rvalid  output  1  port A read data valid
a_rdata  output  DATA_WIDTH  port A read data
a_err  output  1  port A out-of-range flag, qualified by a_rvalid
b_*  (same eight signals as a_*)  port B, identical semantics

Behaviour:
- One clock, clk. Reset rst is synchronous, active-high.
- Address map:
  - BO = log2(DATA_WIDTH/8); word = addr >> BO; low BO bits ignored.
  - bank = word[log2(NUM_BANKS)-1:0]; row = next log2(WORDS_PER_BANK) bits.
  - Total = NUM_BANKS*WORDS_PER_BANK words.
- Grant (combinational from req, address and priority state):
  - Requests to different banks: both granted in the same cycle.
  - Requests to the same bank: only the priority port is granted.
  - Priority register resets to A. After any conflict cycle it points to the port that lost.
  - Non-conflict cycles leave priority unchanged.
- Write: on a granted cycle with we=1, each byte i with be[i]=1 is updated at the clock edge. be=0 is granted but is a no-op. Writes produce no rvalid.
- Read:
  - rvalid pulses exactly READ_LATENCY cycles after the grant edge, one pulse per granted read.
  - rdata holds its last value while rvalid=0.
  - Back-to-back grants give back-to-back rvalid; throughput is 1 read/cycle/port.
- Read-after-write: a read granted in the cycle after a write to the same word returns the new data.
- A port with req=0 never receives gnt. gnt is 0 whenever rst=1.
- Reset values: a_gnt/b_gnt=0, a_rvalid/b_rvalid=0, a_rdata/b_rdata=0, a_err/b_err=0, priority=A.
- Reset mid-operation: all in-flight read-pipeline entries are discarded and no rvalid issues for them. RAM contents are NOT cleared.
- Word addresses >= Total: handled per the optional feature below.

Optional Feature:
- Macro: RAM_BOUNDS_CHECK_EN.
- Defined:
  - A request whose word >= Total is still granted.
  - A write is suppressed.
  - A read returns rdata=0 with err=1 on its rvalid cycle.
  - Out-of-range requests still take part in bank arbitration.
- Undefined:
  - Upper word bits are ignored; the address aliases modulo Total.
  - err outputs are tied to 0.

Test Plan (DATA_WIDTH=32, NUM_BANKS=2, WORDS_PER_BANK=256, READ_LATENCY=2):
1. A writes 0xDEADBEEF, be=0xF, to 0x0; then A reads 0x0 -> a_gnt on the request cycle; a_rvalid 2 cycles later with a_rdata=0xDEADBEEF, a_err=0.
2. Word 0x4 holds 0xAABBCCDD; B writes 0x11223344 with be=0b0101; B reads 0x4 -> b_rdata=0xAA22CC44.
3. Same cycle: A reads 0x0 (bank 0), B reads 0x4 (bank 1) -> both gnt in cycle 0; both rvalid in cycle 2.
4. A reads 0x0 and B reads 0x8 (both bank 0), held -> cycle 0 a_gnt only, cycle 1 b_gnt. A repeated conflict then grants B first. Assert gnt is never high for both ports on the same bank.
5. Granted read of 0x0, then rst=1 for one cycle on the next edge -> no a_rvalid; a_rdata=0. A re-read after reset returns the pre-reset 0xDEADBEEF.
6. A reads 0x800 (word 512):
   - RAM_BOUNDS_CHECK_EN defined -> a_rvalid with a_err=1, a_rdata=0.
   - Undefined -> aliases word 0, returns 0xDEADBEEF with a_err=0.
